i_cache_assoc: RTL
==================

Name: i_cache_assoc

Overview:
Parametrised N-way set-associative instruction cache for the IFU. It integrates tag/data/valid storage, tree-PLRU replacement, a miss/refill FSM and flush support. It sits between the fetch stage (valid/ready request, 1-cycle hit response) and the instruction memory (line-granular valid/ready request, single-beat line response). It supersedes the fixed-geometry i_cache + plru pair.

Parameters:
WAYS_NUM, 4, associativity; power of 2, >= 2
SETS_NUM, 16, sets; power of 2, >= 2
LINE_BYTES, 16, line size; power of 2, >= 8
ADDR_W, 32, address width
LINE_W, LINE_BYTES*8, derived; refill data width

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
core_req_valid  in  1  fetch request valid
core_req_ready  out  1  cache can accept a request
core_req_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored
core_rsp_valid  out  1  instruction valid, one-cycle pulse
core_rsp_data  out  32  instruction word
mem_req_valid  out  1  line fill request
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  line-aligned fill address
mem_rsp_valid  in  1  fill line valid, one-cycle pulse
mem_rsp_data  in  LINE_W  fill line; word k at bits [32k+31:32k]
flush  in  1  invalidate entire cache
busy  out  1  FSM not IDLE, or a flush is pending
hit_cnt  out  32  saturating hit counter
miss_cnt  out  32  saturating miss counter

Behaviour:
- Address split: offset = log2(LINE_BYTES) LSBs (word select = offset[..:2]), index = next log2(SETS_NUM) bits, tag = remaining bits.
- Reset (rst=0, async): state IDLE; all valid bits 0; PLRU bits 0; flush_pending 0; core_rsp_valid 0; core_rsp_data 0; mem_req_valid 0; mem_req_addr 0; hit_cnt 0; miss_cnt 0; busy 0.
- core_req_ready = (state==IDLE) & ~flush. It reads 1 after reset when flush is low.
- Accept happens when core_req_valid & core_req_ready on cycle N.
- Hit on N: core_rsp_valid=1 on N+1 with the selected word. hit_cnt++. PLRU updated for that set and way.
- Miss on N: miss_cnt++. Latch address. State goes to MISS_REQ on N+1.
- MISS_REQ: mem_req_valid=1 with mem_req_addr = latched address with offset zeroed. Both are held stable until mem_req_ready. On handshake, go to MISS_WAIT next cycle and drop mem_req_valid.
- MISS_WAIT: wait for mem_rsp_valid. On cycle M:
  - write the line into the victim way; set valid; write tag; update PLRU;
  - on M+1, core_rsp_valid=1 with the requested word from the fill line;
  - state returns to IDLE on M+1, so a new request can be accepted on M+1.
- mem_rsp_valid outside MISS_WAIT is ignored.
- Victim selection: the lowest-index invalid way in the set. If all are valid, walk the PLRU tree (WAYS_NUM-1 bits per set). A node bit of 0 selects the left (lower) half.
- PLRU update on hit or fill of way w: every node on w's path is set to point away from w.
- Flush in IDLE: in the same cycle core_req_ready=0 and no request is accepted (flush wins over a simultaneous request). The next edge clears all valid bits and all PLRU bits.
- Flush in MISS_REQ or MISS_WAIT: sets flush_pending. The refill and core response complete normally. The cycle after the response, all valids and PLRU bits are cleared and flush_pending is cleared.
- busy = (state!=IDLE) | flush_pending.
- Counters saturate at 0xFFFFFFFF. Flush does not clear them.
- Reset mid-miss: everything returns to reset values immediately, and mem_req_valid drops asynchronously. A late mem_rsp_valid after release is ignored and produces no core_rsp_valid.

Test Plan:
(WAYS_NUM=4, SETS_NUM=16, LINE_BYTES=16)
1. Cold miss then hit: request 0x100 -> mem_req_addr=0x100; return line {0xD3,0xD2,0xD1,0xD0} -> core_rsp_data=0xD0 one cycle after mem_rsp_valid. Then request 0x104 -> core_rsp_data=0xD1 the next cycle; hit_cnt=1, miss_cnt=1.
2. Memory backpressure: miss on 0x200 with mem_req_ready=0 for 5 cycles -> mem_req_valid=1 and mem_req_addr=0x200 stable throughout, core_req_ready=0, no core_rsp_valid.
3. PLRU eviction: fill set 0 with 0x000, 0x100, 0x200, 0x300 (ways 0-3), hit 0x000, then miss 0x400 -> victim is way 2 (0x200). Afterwards 0x100 hits and 0x200 misses.
4. Flush in IDLE: after test 1, assert flush alongside core_req_valid (0x100) -> core_req_ready=0 that cycle. Next request 0x100 misses; miss_cnt increments and hit_cnt is unchanged.
5. Flush during MISS_WAIT: miss 0x300, pulse flush -> busy=1, response still delivers the correct word. One cycle later busy=0; re-request 0x300 misses.
6. Reset mid-miss: assert rst low while in MISS_REQ -> mem_req_valid=0 immediately and counters=0. A mem_rsp_valid pulse after release gives no core_rsp_valid, and core_req_ready=1.

Source files
------------

// File: rtl/i_cache_assoc.sv
// i_cache_assoc: N-way set-associative instruction cache with tree-PLRU
// replacement, a single outstanding line refill and whole-cache flush.
//
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   core_req_*           fetch request (valid/ready, byte address)
//   core_rsp_*           one-cycle instruction response pulse + word
//   mem_req_*            line fill request (valid/ready, line-aligned address)
//   mem_rsp_*            single-beat fill line pulse + data
//   flush                invalidate every line (deferred while a miss is open)
//   busy                 refill in progress or flush still pending
//   hit_cnt, miss_cnt    saturating event counters, cleared only by reset
module i_cache_assoc #(
  parameter int WAYS_NUM   = 4,
  parameter int SETS_NUM   = 16,
  parameter int LINE_BYTES = 16,
  parameter int ADDR_W     = 32,
  parameter int LINE_W     = LINE_BYTES * 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req_valid,
  output logic              core_req_ready,
  input  logic [ADDR_W-1:0] core_req_addr,
  output logic              core_rsp_valid,
  output logic [31:0]       core_rsp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [LINE_W-1:0] mem_rsp_data,
  input  logic              flush,
  output logic              busy,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS_NUM);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int WORD_W = OFF_W - 2;
  localparam int WAY_W  = $clog2(WAYS_NUM);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MISS_REQ  = 2'd1,
    S_MISS_WAIT = 2'd2
  } state_t;

  state_t state_r;

  logic [WAYS_NUM-1:0] valid_r [SETS_NUM];
  logic [WAYS_NUM-2:0] plru_r  [SETS_NUM];
  logic [TAG_W-1:0]    tag_r   [SETS_NUM][WAYS_NUM];
  logic [LINE_W-1:0]   data_r  [SETS_NUM][WAYS_NUM];

  logic                flush_pending_r;
  logic [TAG_W-1:0]    miss_tag_r;
  logic [IDX_W-1:0]    miss_idx_r;
  logic [WORD_W-1:0]   miss_word_r;

  logic [TAG_W-1:0]    req_tag_s;
  logic [IDX_W-1:0]    req_idx_s;
  logic [WORD_W-1:0]   req_word_s;
  logic [WAYS_NUM-1:0] hit_vec_s;
  logic [WAY_W-1:0]    hit_way_s;
  logic                hit_s;
  logic                accept_s;
  logic                fill_s;
  logic [WAY_W-1:0]    victim_s;
  logic [31:0]         hit_word_s;
  logic                addr_unused_s;

  // Select one 32-bit word of a line.
  function automatic logic [31:0] sel_word(input logic [LINE_W-1:0] line,
                                           input logic [WORD_W-1:0] w);
    return line[{w, 5'b00000} +: 32];
  endfunction

  // Walk the PLRU tree from the root; node n has children 2n and 2n+1
  // (1-based heap numbering), a 0 bit selects the lower half.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS_NUM-2:0] bits);
    int node;
    node = 1;
    for (int l = 0; l < WAY_W; l++) begin
      node = 2 * node + int'(bits[node-1]);
    end
    return WAY_W'(node - WAYS_NUM);
  endfunction

  // Make every node on the path to 'way' point away from it.
  function automatic logic [WAYS_NUM-2:0] plru_touch(input logic [WAYS_NUM-2:0] bits,
                                                     input logic [WAY_W-1:0]    way);
    logic [WAYS_NUM-2:0] res;
    logic                dir;
    int                  node;
    res  = bits;
    node = 1;
    for (int l = 0; l < WAY_W; l++) begin
      dir           = way[WAY_W-1-l];
      res[node-1]   = ~dir;
      node          = 2 * node + int'(dir);
    end
    return res;
  endfunction

  // Lowest-index invalid way wins; only a full set consults the PLRU tree.
  function automatic logic [WAY_W-1:0] find_victim(input logic [WAYS_NUM-1:0] valid,
                                                   input logic [WAYS_NUM-2:0] bits);
    logic [WAY_W-1:0] v;
    v = plru_victim(bits);
    for (int w = WAYS_NUM - 1; w >= 0; w--) begin
      v = valid[w] ? v : WAY_W'(w);
    end
    return v;
  endfunction

  assign req_tag_s     = core_req_addr[ADDR_W-1:OFF_W+IDX_W];
  assign req_idx_s     = core_req_addr[OFF_W+IDX_W-1:OFF_W];
  assign req_word_s    = core_req_addr[OFF_W-1:2];
  assign addr_unused_s = ^core_req_addr[1:0];

  assign core_req_ready = (state_r == S_IDLE) & ~flush;
  assign accept_s       = core_req_valid & core_req_ready;
  assign fill_s         = (state_r == S_MISS_WAIT) & mem_rsp_valid;
  assign busy           = (state_r != S_IDLE) | flush_pending_r;
  assign victim_s       = find_victim(valid_r[miss_idx_r], plru_r[miss_idx_r]);

  // Tag compare across all ways of the indexed set; tags are unique per set,
  // so OR-ing the way numbers of the hit vector yields the hit way.
  always_comb begin
    hit_vec_s = '0;
    hit_way_s = '0;
    for (int w = 0; w < WAYS_NUM; w++) begin
      hit_vec_s[w] = valid_r[req_idx_s][w] && (tag_r[req_idx_s][w] == req_tag_s);
      hit_way_s    = hit_way_s | ({WAY_W{hit_vec_s[w]}} & WAY_W'(w));
    end
    // While a deferred flush is still pending, treat every lookup as a miss so
    // a line that is about to be invalidated is never returned.
    hit_s      = (|hit_vec_s) & ~flush_pending_r;
    hit_word_s = sel_word(data_r[req_idx_s][hit_way_s], req_word_s);
  end

  // Line and tag storage: written only on refill; valid bits gate every lookup.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      data_r[miss_idx_r][victim_s] <= mem_rsp_data;
      tag_r[miss_idx_r][victim_s]  <= miss_tag_r;
    end
  end

  // Control FSM with valid/PLRU state, registered responses and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r         <= S_IDLE;
      flush_pending_r <= 1'b0;
      core_rsp_valid  <= 1'b0;
      core_rsp_data   <= 32'h0000_0000;
      mem_req_valid   <= 1'b0;
      mem_req_addr    <= '0;
      hit_cnt         <= 32'h0000_0000;
      miss_cnt        <= 32'h0000_0000;
      miss_tag_r      <= '0;
      miss_idx_r      <= '0;
      miss_word_r     <= '0;
      for (int s = 0; s < SETS_NUM; s++) begin
        valid_r[s] <= '0;
        plru_r[s]  <= '0;
      end
    end else begin
      core_rsp_valid <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            if (hit_s) begin
              core_rsp_valid    <= 1'b1;
              core_rsp_data     <= hit_word_s;
              plru_r[req_idx_s] <= plru_touch(plru_r[req_idx_s], hit_way_s);
              if (hit_cnt != 32'hFFFF_FFFF) begin
                hit_cnt <= hit_cnt + 32'd1;
              end
            end else begin
              miss_tag_r    <= req_tag_s;
              miss_idx_r    <= req_idx_s;
              miss_word_r   <= req_word_s;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {core_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              state_r       <= S_MISS_REQ;
              if (miss_cnt != 32'hFFFF_FFFF) begin
                miss_cnt <= miss_cnt + 32'd1;
              end
            end
          end
          // Immediate flush, or the deferred one the cycle after a refill response.
          if (flush || flush_pending_r) begin
            flush_pending_r <= 1'b0;
            for (int s = 0; s < SETS_NUM; s++) begin
              valid_r[s] <= '0;
              plru_r[s]  <= '0;
            end
          end
        end
        S_MISS_REQ: begin
          if (flush) begin
            flush_pending_r <= 1'b1;
          end
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state_r       <= S_MISS_WAIT;
          end
        end
        S_MISS_WAIT: begin
          if (flush) begin
            flush_pending_r <= 1'b1;
          end
          if (mem_rsp_valid) begin
            valid_r[miss_idx_r][victim_s] <= 1'b1;
            plru_r[miss_idx_r]            <= plru_touch(plru_r[miss_idx_r], victim_s);
            core_rsp_valid                <= 1'b1;
            core_rsp_data                 <= sel_word(mem_rsp_data, miss_word_r);
            state_r                       <= S_IDLE;
          end
        end
        default: begin
          state_r       <= S_IDLE;
          mem_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
